// File: rtl/vga_test_pattern_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_test_pattern_if
// Description : Pixel position, mode request and colour/status bundle for
//               the VGA test pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_test_pattern_if #(
  parameter int COLOR_BITS = 4,
  parameter int H_WHOLE    = 800,
  parameter int V_WHOLE    = 525
);
  logic [$clog2(H_WHOLE)-1:0] column;
  logic [$clog2(V_WHOLE)-1:0] row;
  logic [1:0]                 mode_req;
  logic [COLOR_BITS-1:0]      red;
  logic [COLOR_BITS-1:0]      green;
  logic [COLOR_BITS-1:0]      blue;
  logic [1:0]                 mode;
  logic [7:0]                 frame_count;

  modport master (
    output column, row, mode_req,
    input  red, green, blue, mode, frame_count
  );

  modport slave (
    input  column, row, mode_req,
    output red, green, blue, mode, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_test_pattern.sv
`default_nettype none
// ============================================================================
// Module      : vga_test_pattern
// Description : Multi-mode VGA test pattern generator (bars, checker,
//               gradient, scrolling bars); mode switches only at end of frame.
//               Optional border: define VGA_TEST_PATTERN_BORDER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_test_pattern #(
  parameter int COLOR_BITS    = 4,
  parameter int NUM_BARS      = 8,
  parameter int H_VISIBLE     = 640,
  parameter int H_WHOLE       = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_WHOLE       = 525,
  parameter int CHECK_SHIFT   = 5,
  parameter int SCROLL_FRAMES = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_test_pattern_if.slave   vga
);

  localparam int c_col_w    = $clog2(H_WHOLE);
  localparam int c_row_w    = $clog2(V_WHOLE);
  localparam int c_bar_w    = H_VISIBLE / NUM_BARS;
  localparam int c_bars_end = NUM_BARS * c_bar_w;
  localparam int c_px_w     = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;
  localparam int c_idx_w    = $clog2(NUM_BARS + 1);
  localparam int c_div_w    = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int c_off_w    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int c_red_bits = (COLOR_BITS < 10) ? COLOR_BITS : 10;
  localparam int c_grn_bits = (COLOR_BITS < 9) ? COLOR_BITS : 9;
  localparam int c_blu_bits = (COLOR_BITS < 8) ? COLOR_BITS : 8;
  localparam logic [COLOR_BITS-1:0] c_ones = {COLOR_BITS{1'b1}};

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SCROLL   = 2'd3
  } mode_t;

  mode_t                 r_mode;
  logic [7:0]            r_frame;
  logic [c_div_w-1:0]    r_div;
  logic [c_off_w-1:0]    r_off;
  logic [c_px_w-1:0]     r_bar_px;
  logic [c_idx_w-1:0]    r_bar_idx;
  logic [COLOR_BITS-1:0] r_red, r_green, r_blue;

  logic                  w_eof, w_visible, w_in_bars, w_border, w_unused;
  logic [15:0]           w_col_ext, w_row_ext;
  logic [c_px_w-1:0]     w_bar_px;
  logic [c_idx_w-1:0]    w_bar_idx;
  logic [c_idx_w:0]      w_sum;
  logic [2:0]            w_code;
  logic [COLOR_BITS-1:0] w_red, w_green, w_blue;

  assign w_col_ext = 16'(vga.column);
  assign w_row_ext = 16'(vga.row);
  assign w_unused  = ^{w_col_ext, w_row_ext};

  assign w_eof     = (vga.column == c_col_w'(H_WHOLE - 1)) && (vga.row == c_row_w'(V_WHOLE - 1));
  assign w_visible = (vga.column < c_col_w'(H_VISIBLE)) && (vga.row < c_row_w'(V_VISIBLE));
  assign w_in_bars = vga.column < c_col_w'(c_bars_end);

`ifdef VGA_TEST_PATTERN_BORDER_EN
  assign w_border = (vga.column == '0) || (vga.column == c_col_w'(H_VISIBLE - 1)) ||
                    (vga.row == '0) || (vga.row == c_row_w'(V_VISIBLE - 1));
`else
  assign w_border = 1'b0;
`endif

  // Bar position of the current column, derived from the previous column's
  // registered position so no divider is needed.
  always_comb begin
    w_bar_px  = '0;
    w_bar_idx = '0;
    if (vga.column != '0) begin
      if (r_bar_px == c_px_w'(c_bar_w - 1)) begin
        w_bar_px  = '0;
        w_bar_idx = (r_bar_idx < c_idx_w'(NUM_BARS)) ? r_bar_idx + 1'b1 : r_bar_idx;
      end else begin
        w_bar_px  = r_bar_px + 1'b1;
        w_bar_idx = r_bar_idx;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, w_bar_idx} + (c_idx_w + 1)'(r_off);
    if (w_sum >= (c_idx_w + 1)'(NUM_BARS))
      w_sum = w_sum - (c_idx_w + 1)'(NUM_BARS);
  end

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    w_code  = (r_mode == MODE_SCROLL) ? 3'(w_sum) : 3'(w_bar_idx);
    case (r_mode)
      MODE_BARS, MODE_SCROLL: begin
        if (w_in_bars) begin
          w_red   = w_code[2] ? c_ones : '0;
          w_green = w_code[1] ? c_ones : '0;
          w_blue  = w_code[0] ? c_ones : '0;
        end
      end
      MODE_CHECKER: begin
        if (w_col_ext[CHECK_SHIFT] ^ w_row_ext[CHECK_SHIFT]) begin
          w_red   = c_ones;
          w_green = c_ones;
          w_blue  = c_ones;
        end
      end
      MODE_GRADIENT: begin
        w_red   = COLOR_BITS'(w_col_ext[9 -: c_red_bits]);
        w_green = COLOR_BITS'(w_row_ext[8 -: c_grn_bits]);
        w_blue  = COLOR_BITS'(r_frame[c_blu_bits-1:0]);
      end
      default: ;
    endcase
    if (w_border) begin
      w_red   = c_ones;
      w_green = c_ones;
      w_blue  = c_ones;
    end
    if (!w_visible) begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode    <= MODE_BARS;
      r_frame   <= '0;
      r_div     <= '0;
      r_off     <= '0;
      r_bar_px  <= '0;
      r_bar_idx <= '0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
    end else begin
      r_bar_px  <= w_bar_px;
      r_bar_idx <= w_bar_idx;
      r_red     <= w_red;
      r_green   <= w_green;
      r_blue    <= w_blue;
      if (w_eof) begin
        r_mode  <= mode_t'(vga.mode_req);
        r_frame <= r_frame + 8'd1;
        if (r_div == c_div_w'(SCROLL_FRAMES - 1)) begin
          r_div <= '0;
          r_off <= (r_off == c_off_w'(NUM_BARS - 1)) ? '0 : r_off + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign vga.red         = r_red;
  assign vga.green       = r_green;
  assign vga.blue        = r_blue;
  assign vga.mode        = r_mode;
  assign vga.frame_count = r_frame;

endmodule
`default_nettype wire
